axis_frame_sanitizer: RTL and testbench

Receives an 8-bit AXI4-Stream video stream from the video source and repairs its framing before it reaches the 5x5 median filter. Every frame it forwards has exactly `width` pixels per line, `height` lines, `tuser` on pixel (0,0) and `tlast` on pixel `width-1` of each line. It corrects dropped `tuser`, early or late `tlast`, and early start-of-frame, and reports each correction on error pulses and counters. Valid gaps are legal and pass through without error.

---
 rtl/axis_video_pkg.sv | 19 +
 rtl/axis_out_reg.sv | 38 +++
 rtl/axis_frame_sanitizer.sv | 203 ++++++++++++++++++++
 tb/tb_axis_frame_sanitizer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_video_pkg.sv
// rtl/axis_video_pkg.sv - shared types and constants for the video framing path
package axis_video_pkg;

   typedef enum logic [2:0] {
      WAIT_SOF,
      ACTIVE,
      PAD,
      PAD_SOF,
      DISCARD
   } san_state_t;

   localparam int PAD_VALUE_DEFAULT = 0;

   // Counter increment that sticks at all-ones instead of wrapping
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axis_out_reg.sv
// rtl/axis_out_reg.sv - one-entry AXIS register slice feeding the median filter
module axis_out_reg #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [N-1:0] in_data,
   input  logic         in_user,
   input  logic         in_last,
   output logic         load_ready,
   output logic [N-1:0] m_tdata,
   output logic         m_tvalid,
   output logic         m_tuser,
   output logic         m_tlast,
   input  logic         m_tready
);

   assign load_ready = ~m_tvalid | m_tready;

   // Load a new beat whenever the slot is empty or being drained; hold otherwise
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tuser  <= 1'b0;
         m_tlast  <= 1'b0;
      end else if (load_ready) begin
         m_tvalid <= in_valid;
         if (in_valid) begin
            m_tdata <= in_data;
            m_tuser <= in_user;
            m_tlast <= in_last;
         end
      end
   end

endmodule

// File: rtl/axis_frame_sanitizer.sv
// rtl/axis_frame_sanitizer.sv - repairs SOF/EOL framing of an AXIS video stream
module axis_frame_sanitizer
   import axis_video_pkg::*;
#(
   parameter int N         = 8,
   parameter int width     = 10,
   parameter int height    = 10,
   parameter int PAD_VALUE = PAD_VALUE_DEFAULT
) (
   input  logic         sys_clk,
   input  logic         sys_areset,
   input  logic [N-1:0] s_axis_tdata,
   input  logic         s_axis_tvalid,
   input  logic         s_axis_tuser,
   input  logic         s_axis_tlast,
   output logic         s_axis_tready,
   output logic [N-1:0] m_axis_tdata,
   output logic         m_axis_tvalid,
   output logic         m_axis_tuser,
   output logic         m_axis_tlast,
   input  logic         m_axis_tready,
   output logic         err_sof_missing,
   output logic         err_sof_early,
   output logic         err_tlast_early,
   output logic         err_tlast_late,
   output logic [15:0]  frame_cnt,
   output logic [15:0]  err_cnt
);

   localparam int PXW = (width  > 1) ? $clog2(width)  : 1;
   localparam int LNW = (height > 1) ? $clog2(height) : 1;
   localparam logic [PXW-1:0] PX_LAST  = PXW'(width - 1);
   localparam logic [LNW-1:0] LN_LAST  = LNW'(height - 1);
   localparam logic [N-1:0]   PAD_DATA = N'(PAD_VALUE);

   san_state_t     state;
   logic [PXW-1:0] px;
   logic [LNW-1:0] ln;

   logic           o_ready;
   logic           emit;
   logic [N-1:0]   e_data;
   logic           e_user;
   logic           e_last;

   logic at_line_end, at_last_ln, at_sof, early_sof;
   logic nx_sof_missing, nx_sof_early, nx_tlast_early, nx_tlast_late;
   logic frame_done;

   assign at_line_end = (px == PX_LAST);
   assign at_last_ln  = (ln == LN_LAST);
   assign at_sof      = (px == '0) && (ln == '0);
   assign early_sof   = s_axis_tuser && !at_sof;

   // Decode ready and the beat offered to the output register from state and position
   always_comb begin
      s_axis_tready = 1'b0;
      emit          = 1'b0;
      e_data        = s_axis_tdata;
      e_user        = 1'b0;
      e_last        = 1'b0;
      case (state)
         WAIT_SOF: begin
            // Junk is always swallowed; a SOF beat must wait for room downstream
            s_axis_tready = s_axis_tuser ? o_ready : 1'b1;
            if (s_axis_tvalid && s_axis_tuser && o_ready) begin
               emit   = 1'b1;
               e_user = 1'b1;
            end
         end
         ACTIVE: begin
            s_axis_tready = early_sof ? 1'b0 : o_ready;
            if (s_axis_tvalid && !early_sof && o_ready) begin
               emit   = 1'b1;
               e_last = at_line_end;
            end
         end
         PAD, PAD_SOF: begin
            e_data = PAD_DATA;
            e_last = at_line_end;
            emit   = o_ready && !(state == PAD_SOF && px == '0);
         end
         DISCARD: begin
            // A new SOF is left waiting upstream for WAIT_SOF to take
            s_axis_tready = !s_axis_tuser;
         end
         default: ;
      endcase
   end

   assign nx_sof_missing = (state == WAIT_SOF) && s_axis_tvalid && !s_axis_tuser;
   assign nx_sof_early   = (state == ACTIVE) && s_axis_tvalid && early_sof;
   assign nx_tlast_early = emit && s_axis_tlast && !at_line_end &&
                           (state == WAIT_SOF || state == ACTIVE);
   assign nx_tlast_late  = (state == ACTIVE) && emit && at_line_end && !s_axis_tlast;
   assign frame_done     = emit && at_line_end && at_last_ln &&
                           (state == ACTIVE || state == PAD);

   axis_out_reg #(.N(N)) u_out_reg (
      .clk        (sys_clk),
      .rst        (sys_areset),
      .in_valid   (emit),
      .in_data    (e_data),
      .in_user    (e_user),
      .in_last    (e_last),
      .load_ready (o_ready),
      .m_tdata    (m_axis_tdata),
      .m_tvalid   (m_axis_tvalid),
      .m_tuser    (m_axis_tuser),
      .m_tlast    (m_axis_tlast),
      .m_tready   (m_axis_tready)
   );

   // Framing FSM: position counters advance on output beats, error pulses and counters registered
   always_ff @(posedge sys_clk or posedge sys_areset) begin
      if (sys_areset) begin
         state           <= WAIT_SOF;
         px              <= '0;
         ln              <= '0;
         err_sof_missing <= 1'b0;
         err_sof_early   <= 1'b0;
         err_tlast_early <= 1'b0;
         err_tlast_late  <= 1'b0;
         frame_cnt       <= '0;
         err_cnt         <= '0;
      end else begin
         err_sof_missing <= nx_sof_missing;
         err_sof_early   <= nx_sof_early;
         err_tlast_early <= nx_tlast_early;
         err_tlast_late  <= nx_tlast_late;
         if (nx_sof_missing || nx_sof_early || nx_tlast_early || nx_tlast_late)
            err_cnt <= sat_inc16(err_cnt);
         frame_cnt <= frame_cnt + 16'(frame_done);

         case (state)
            WAIT_SOF: begin
               if (emit) begin
                  px    <= px + PXW'(1);
                  state <= s_axis_tlast ? PAD : ACTIVE;
               end
            end
            ACTIVE: begin
               if (nx_sof_early) begin
                  state <= PAD_SOF;
               end else if (emit) begin
                  if (at_line_end) begin
                     px <= '0;
                     ln <= at_last_ln ? '0 : ln + LNW'(1);
                     if (!s_axis_tlast)
                        state <= DISCARD;
                     else if (at_last_ln)
                        state <= WAIT_SOF;
                  end else begin
                     px <= px + PXW'(1);
                     if (s_axis_tlast)
                        state <= PAD;
                  end
               end
            end
            PAD: begin
               if (emit) begin
                  if (at_line_end) begin
                     px    <= '0;
                     ln    <= at_last_ln ? '0 : ln + LNW'(1);
                     state <= at_last_ln ? WAIT_SOF : ACTIVE;
                  end else begin
                     px <= px + PXW'(1);
                  end
               end
            end
            PAD_SOF: begin
               // Truncated frame: finish this line only, then restart at (0,0)
               if (px == '0) begin
                  ln    <= '0;
                  state <= WAIT_SOF;
               end else if (emit) begin
                  if (at_line_end) begin
                     px    <= '0;
                     ln    <= '0;
                     state <= WAIT_SOF;
                  end else begin
                     px <= px + PXW'(1);
                  end
               end
            end
            DISCARD: begin
               if (s_axis_tvalid) begin
                  if (s_axis_tuser) begin
                     px    <= '0;
                     ln    <= '0;
                     state <= WAIT_SOF;
                  end else if (s_axis_tlast) begin
                     // Counters already wrapped to line 0 when the late line closed the frame
                     state <= (ln == '0) ? WAIT_SOF : ACTIVE;
                  end
               end
            end
            default: state <= WAIT_SOF;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_frame_sanitizer.sv
// tb/tb_axis_frame_sanitizer.sv - directed self-checking bench for axis_frame_sanitizer
module tb_axis_frame_sanitizer;

   logic        sys_clk = 1'b0;
   logic        sys_areset = 1'b0;
   logic [7:0]  s_axis_tdata = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tuser = 1'b0;
   logic        s_axis_tlast = 1'b0;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tuser;
   logic        m_axis_tlast;
   logic        m_axis_tready = 1'b1;
   logic        err_sof_missing, err_sof_early, err_tlast_early, err_tlast_late;
   logic [15:0] frame_cnt, err_cnt;

   int n_checks = 0;
   int n_fail = 0;
   int timeouts = 0;
   int c_miss = 0, c_sof_early = 0, c_tl_early = 0, c_tl_late = 0;
   logic gaps = 1'b0;
   logic bp = 1'b0;
   logic [9:0] outq[$];

   axis_frame_sanitizer #(.N(8), .width(10), .height(10), .PAD_VALUE(0)) dut (
      .sys_clk         (sys_clk),
      .sys_areset      (sys_areset),
      .s_axis_tdata    (s_axis_tdata),
      .s_axis_tvalid   (s_axis_tvalid),
      .s_axis_tuser    (s_axis_tuser),
      .s_axis_tlast    (s_axis_tlast),
      .s_axis_tready   (s_axis_tready),
      .m_axis_tdata    (m_axis_tdata),
      .m_axis_tvalid   (m_axis_tvalid),
      .m_axis_tuser    (m_axis_tuser),
      .m_axis_tlast    (m_axis_tlast),
      .m_axis_tready   (m_axis_tready),
      .err_sof_missing (err_sof_missing),
      .err_sof_early   (err_sof_early),
      .err_tlast_early (err_tlast_early),
      .err_tlast_late  (err_tlast_late),
      .frame_cnt       (frame_cnt),
      .err_cnt         (err_cnt)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge sys_clk);
         #1;
         m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge sys_clk) begin
      if (m_axis_tvalid && m_axis_tready)
         outq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
      if (err_sof_missing) c_miss++;
      if (err_sof_early)   c_sof_early++;
      if (err_tlast_early) c_tl_early++;
      if (err_tlast_late)  c_tl_late++;
   end

   function automatic logic [7:0] pix(input int f, input int l, input int p);
      return 8'(f * 37 + l * 10 + p + 1);
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      outq.delete();
      c_miss = 0; c_sof_early = 0; c_tl_early = 0; c_tl_late = 0;
      timeouts = 0;
   endtask

   task automatic idle(input int n);
      s_axis_tvalid = 1'b0;
      repeat (n) begin
         @(posedge sys_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      sys_areset = 1'b1;
      idle(2);
      sys_areset = 1'b0;
      idle(1);
      clear_obs();
   endtask

   task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
      int   n;
      logic done;
      n = 0;
      done = 1'b0;
      if (gaps && $urandom_range(0, 3) == 0) idle(1);
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      while (!done) begin
         @(negedge sys_clk);
         done = s_axis_tready;
         @(posedge sys_clk);
         #1;
         n++;
         if (!done && n > 300) begin
            timeouts++;
            done = 1'b1;
         end
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_frame(input int f, input logic sof_ok);
      for (int l = 0; l < 10; l++)
         for (int p = 0; p < 10; p++)
            send_beat(pix(f, l, p), sof_ok && l == 0 && p == 0, p == 9);
   endtask

   function automatic int bad_frame(input int start, input int f);
      int bad;
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         if (start + i >= outq.size())
            bad++;
         else if (outq[start + i] !== {i == 0, (i % 10) == 9, pix(f, i / 10, i % 10)})
            bad++;
      end
      return bad;
   endfunction

   initial begin
      int bad;
      logic [9:0] ev;

      // Reset state
      #2 sys_areset = 1'b1;
      #1;
      chk("reset_tvalid", int'(m_axis_tvalid), 0);
      chk("reset_tdata", int'(m_axis_tdata), 0);
      chk("reset_frame_cnt", int'(frame_cnt), 0);
      chk("reset_err_cnt", int'(err_cnt), 0);
      @(posedge sys_clk);
      #1;
      sys_areset = 1'b0;
      idle(1);
      clear_obs();

      // Clean stream with valid gaps
      gaps = 1'b1;
      for (int f = 0; f < 3; f++) send_frame(f, 1'b1);
      idle(6);
      chk("clean_count", outq.size(), 300);
      chk("clean_f0", bad_frame(0, 0), 0);
      chk("clean_f1", bad_frame(100, 1), 0);
      chk("clean_f2", bad_frame(200, 2), 0);
      chk("clean_frame_cnt", int'(frame_cnt), 3);
      chk("clean_err_cnt", int'(err_cnt), 0);
      chk("clean_timeouts", timeouts, 0);

      // Early tlast on line 0 px 6
      do_reset();
      for (int l = 0; l < 10; l++)
         for (int p = 0; p < ((l == 0) ? 7 : 10); p++)
            send_beat(pix(1, l, p), l == 0 && p == 0, p == ((l == 0) ? 6 : 9));
      idle(6);
      chk("etl_count", outq.size(), 100);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         ev = {i == 0, (i % 10) == 9, (i >= 7 && i <= 9) ? 8'h00 : pix(1, i / 10, i % 10)};
         if (i >= outq.size() || outq[i] !== ev) bad++;
      end
      chk("etl_beats", bad, 0);
      chk("etl_pulses", c_tl_early, 1);
      chk("etl_frame_cnt", int'(frame_cnt), 1);
      chk("etl_err_cnt", int'(err_cnt), 1);
      chk("etl_timeouts", timeouts, 0);

      // Late tlast: line 0 carries 12 beats, tlast on the 12th
      do_reset();
      for (int l = 0; l < 10; l++)
         for (int p = 0; p < ((l == 0) ? 12 : 10); p++)
            send_beat((p >= 10) ? 8'hEE : pix(1, l, p), l == 0 && p == 0,
                      p == ((l == 0) ? 11 : 9));
      idle(6);
      chk("ltl_count", outq.size(), 100);
      chk("ltl_beats", bad_frame(0, 1), 0);
      chk("ltl_pulses", c_tl_late, 1);
      chk("ltl_early_pulses", c_tl_early, 0);
      chk("ltl_frame_cnt", int'(frame_cnt), 1);
      chk("ltl_err_cnt", int'(err_cnt), 1);

      // Dropped tuser: whole frame discarded, next frame intact
      do_reset();
      send_frame(2, 1'b0);
      idle(4);
      chk("nosof_out_count", outq.size(), 0);
      chk("nosof_pulses", c_miss, 100);
      send_frame(3, 1'b1);
      idle(6);
      chk("nosof_next_frame", bad_frame(0, 3), 0);
      chk("nosof_frame_cnt", int'(frame_cnt), 1);
      chk("nosof_err_cnt", int'(err_cnt), 100);

      // Early tuser at line 3 px 4
      do_reset();
      for (int i = 0; i < 34; i++)
         send_beat(pix(2, i / 10, i % 10), i == 0, (i % 10) == 9);
      send_frame(3, 1'b1);
      idle(6);
      chk("esof_count", outq.size(), 140);
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         ev = {i == 0, (i % 10) == 9, (i >= 34) ? 8'h00 : pix(2, i / 10, i % 10)};
         if (i >= outq.size() || outq[i] !== ev) bad++;
      end
      chk("esof_truncated", bad, 0);
      chk("esof_new_frame", bad_frame(40, 3), 0);
      chk("esof_pulses", c_sof_early, 1);
      chk("esof_frame_cnt", int'(frame_cnt), 1);
      chk("esof_timeouts", timeouts, 0);

      // Backpressure with gaps
      do_reset();
      bp = 1'b1;
      send_frame(0, 1'b1);
      send_frame(1, 1'b1);
      idle(12);
      bp = 1'b0;
      idle(4);
      chk("bp_count", outq.size(), 200);
      chk("bp_f0", bad_frame(0, 0), 0);
      chk("bp_f1", bad_frame(100, 1), 0);
      chk("bp_frame_cnt", int'(frame_cnt), 2);
      chk("bp_timeouts", timeouts, 0);

      // Reset mid-frame at pixel 37
      gaps = 1'b0;
      for (int i = 0; i < 37; i++)
         send_beat(pix(3, i / 10, i % 10), i == 0, (i % 10) == 9);
      sys_areset = 1'b1;
      #1;
      chk("mrst_tvalid", int'(m_axis_tvalid), 0);
      chk("mrst_tdata", int'(m_axis_tdata), 0);
      chk("mrst_tuser_tlast", int'({m_axis_tuser, m_axis_tlast}), 0);
      chk("mrst_frame_cnt", int'(frame_cnt), 0);
      chk("mrst_err_cnt", int'(err_cnt), 0);
      idle(2);
      sys_areset = 1'b0;
      idle(1);
      clear_obs();
      for (int i = 37; i < 42; i++)
         send_beat(pix(3, i / 10, i % 10), 1'b0, (i % 10) == 9);
      idle(4);
      chk("mrst_junk_out", outq.size(), 0);
      chk("mrst_junk_pulses", c_miss, 5);
      send_frame(1, 1'b1);
      idle(6);
      chk("mrst_next_frame", bad_frame(0, 1), 0);
      chk("mrst_next_frame_cnt", int'(frame_cnt), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
